uncached_bridge: RTL and testbench

//  Sits directly downstream of the MMU on the data side: takes the physical address and uncached flag of each MEM-stage

---
 rtl/uncached_bridge.sv | 171 +++++++++++++++++
 tb/tb_uncached_bridge.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncached_bridge.sv
// Uncached data-side bridge: posts stores into a small FIFO write buffer and performs
// blocking loads over the SRAM-like bus once all buffered stores have drained.
module uncached_bridge #(
  parameter int WBUF_DEPTH = 4,
  parameter int WBUF_AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_uncached,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic        flush,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        wbuf_empty_o,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA, R_DONE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } wentry_t;

  localparam logic [WBUF_AW-1:0] PTR_ONE  = WBUF_AW'(1);
  localparam logic [WBUF_AW:0]   CNT_ONE  = (WBUF_AW + 1)'(1);
  localparam logic [WBUF_AW:0]   CNT_FULL = (WBUF_AW + 1)'(WBUF_DEPTH);

  wentry_t              wbuf_q [WBUF_DEPTH];
  logic [WBUF_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [WBUF_AW:0]     count_q, count_d;
  state_t               state_q;
  logic                 killed_q;
  logic                 bus_req_q, bus_wr_q;
  logic [1:0]           bus_size_q;
  logic [31:0]          bus_addr_q, bus_wdata_q, rdata_q;
  logic [3:0]           bus_wstrb_q;
  logic                 rdata_valid_q;

  logic    uc, wbuf_full, push, pop;
  wentry_t head;

  assign uc        = req_valid & req_uncached;
  assign wbuf_full = (count_q == CNT_FULL);
  // Full comes from the registered count, so a pop never makes room for a push in the same cycle.
  assign push      = uc & req_wr & ~wbuf_full;
  assign pop       = (state_q == W_DATA) & bus_data_ok;
  assign head      = wbuf_q[rd_ptr_q];

  assign stall_o       = uc & (req_wr ? wbuf_full : ~((state_q == R_DONE) & ~killed_q));
  assign wbuf_empty_o  = (count_q == '0);
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign bus_req       = bus_req_q;
  assign bus_wr        = bus_wr_q;
  assign bus_size      = bus_size_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wstrb     = bus_wstrb_q;

  // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the entry storage carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) wbuf_q[wr_ptr_q] <= '{addr: req_addr, wdata: req_wdata, wstrb: req_wstrb, size: req_size};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      killed_q      <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_size_q    <= '0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_wstrb_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      count_q       <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;

      case (state_q)
        IDLE: begin
          // Buffered stores win, so a load can never overtake an earlier store.
          if (count_q != '0) begin
            state_q     <= W_ADDR;
            bus_wr_q    <= 1'b1;
            bus_addr_q  <= head.addr;
            bus_wdata_q <= head.wdata;
            bus_wstrb_q <= head.wstrb;
            bus_size_q  <= head.size;
          end else if (uc & ~req_wr & ~flush) begin
            state_q     <= R_ADDR;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= req_addr;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            bus_size_q  <= req_size;
          end
        end
        W_ADDR: begin
          if (bus_req_q & bus_addr_ok) begin
            bus_req_q <= 1'b0;
            state_q   <= W_DATA;
          end else begin
            bus_req_q <= 1'b1;
          end
        end
        W_DATA: if (bus_data_ok) state_q <= IDLE;
        R_ADDR: begin
          if (bus_req_q & bus_addr_ok) begin
            bus_req_q <= 1'b0;
            killed_q  <= flush;
            state_q   <= R_DATA;
          end else if (flush) begin
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            bus_req_q <= 1'b1;
          end
        end
        R_DATA: begin
          // An accepted read must finish on the bus; a flush only hides its result.
          if (flush) killed_q <= 1'b1;
          if (bus_data_ok) begin
            rdata_q       <= bus_rdata;
            rdata_valid_q <= ~(killed_q | flush);
            state_q       <= R_DONE;
          end
        end
        R_DONE: begin
          killed_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uncached_bridge.sv
// Scoreboarded bench for uncached_bridge: a bus responder with programmable handshake delays,
// a queue of expected bus writes and a queue of expected load results.
module tb_uncached_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_uncached = 1'b0, req_wr = 1'b0, flush = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        stall_o, rdata_valid_o, wbuf_empty_o;
  logic [31:0] rdata_o;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] rq[$];
  logic [31:0] amem [logic [31:0]];
  logic [31:0] bmem [logic [31:0]];

  // Bus responder state
  bit          aok_r = 0, dok_r = 0, addr_en = 1, data_en = 1;
  int          addr_wait = 0, data_wait = 0, dcnt = 0, wait_cnt = 0, pulses = 0;
  bit          pending = 0, pend_wr = 0;
  logic        q_req = 0, q_wr = 0;
  logic [31:0] q_addr = '0, q_wdata = '0, rd_word = '0;
  logic [3:0]  q_wstrb = '0;
  logic [1:0]  q_size = '0;
  wr_t         mon_e;

  assign bus_addr_ok = aok_r & addr_en;
  assign bus_data_ok = dok_r & data_en;
  assign bus_rdata   = rd_word;

  uncached_bridge #(.WBUF_DEPTH(4), .WBUF_AW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_uncached(req_uncached), .req_wr(req_wr),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .flush(flush), .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .wbuf_empty_o(wbuf_empty_o), .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Responder: the previous negedge's view of the bus tells what happened at the edge in between.
  always @(negedge clk) begin
    if (rst) begin
      pending = 0; aok_r = 0; dok_r = 0; q_req = 0; wait_cnt = 0;
    end else begin
      if (pending && bus_data_ok) begin
        pending = 0;
        dok_r   = 0;
      end
      if (q_req && bus_addr_ok) begin
        if (q_wr) begin
          n_checks++;
          if (wq.size() == 0) begin
            n_fail++;
            $display("FAIL bus_write unexpected: addr=%h data=%h", q_addr, q_wdata);
          end else begin
            mon_e = wq.pop_front();
            if (q_addr !== mon_e.addr || q_wdata !== mon_e.wdata || q_wstrb !== mon_e.wstrb || q_size !== mon_e.size) begin
              n_fail++;
              $display("FAIL bus_write: got %h/%h/%h/%0d required %h/%h/%h/%0d", q_addr, q_wdata, q_wstrb, q_size,
                       mon_e.addr, mon_e.wdata, mon_e.wstrb, mon_e.size);
            end
          end
          bmem[q_addr] = merge(bmem.exists(q_addr) ? bmem[q_addr] : dflt(q_addr), q_wdata, q_wstrb);
        end else begin
          n_checks++;
          if (q_wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL bus_read_wstrb: got %h required 0", q_wstrb);
          end
          rd_word = bmem.exists(q_addr) ? bmem[q_addr] : dflt(q_addr);
        end
        pending  = 1;
        pend_wr  = q_wr;
        dcnt     = data_wait;
        wait_cnt = 0;
      end else if (q_req) begin
        if (bus_req) begin
          n_checks++;
          if (bus_addr !== q_addr || bus_wdata !== q_wdata || bus_wstrb !== q_wstrb || bus_size !== q_size || bus_wr !== q_wr) begin
            n_fail++;
            $display("FAIL bus_stable: addr %h->%h data %h->%h", q_addr, bus_addr, q_wdata, bus_wdata);
          end
        end
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
      aok_r = bus_req && !pending && (wait_cnt >= addr_wait);
      if (pending) begin
        if (dcnt == 0) dok_r = 1;
        else begin dok_r = 0; dcnt--; end
      end else begin
        dok_r = 0;
      end
      q_req = bus_req; q_wr = bus_wr; q_addr = bus_addr; q_wdata = bus_wdata; q_wstrb = bus_wstrb; q_size = bus_size;
    end
  end

  // Load-result scoreboard
  always @(negedge clk) begin
    if (!rst && rdata_valid_o) begin
      pulses++;
      n_checks++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL rdata_pulse unexpected: rdata_o=%h", rdata_o);
      end else if (rdata_o !== rq[0]) begin
        n_fail++;
        $display("FAIL rdata: got %h required %h", rdata_o, rq[0]);
        void'(rq.pop_front());
      end else begin
        void'(rq.pop_front());
      end
    end
  end

  // All stimulus tasks act at negedge+1 and leave time at negedge+1.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    wr_t e;
    req_valid = 1; req_uncached = 1; req_wr = 1; req_size = 2'd2;
    req_addr = a; req_wdata = d; req_wstrb = 4'hF;
    e = '{a, d, 4'hF, 2'd2};
    wq.push_back(e);
    amem[a] = d;
    #1;
    stalls = 0;
    while (stall_o && stalls < 200) begin
      @(negedge clk); #2;
      stalls++;
    end
    if (stalls >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL store_timeout: addr=%h still stalled", a);
    end
    @(negedge clk); #1;
    req_valid = 0;
  endtask

  task automatic load(input logic [31:0] a, output int lat);
    int p0;
    req_valid = 1; req_uncached = 1; req_wr = 0; req_size = 2'd2; req_addr = a; req_wstrb = 4'h0;
    rq.push_back(amem.exists(a) ? amem[a] : dflt(a));
    p0 = pulses;
    #1;
    lat = 0;
    while (stall_o && lat < 300) begin
      @(negedge clk); #2;
      lat++;
    end
    n_checks++;
    if (lat >= 300 || rdata_valid_o !== 1'b1 || pulses != p0 + 1) begin
      n_fail++;
      $display("FAIL load_complete: addr=%h lat=%0d valid=%b pulses=%0d required valid=1 pulses=%0d", a, lat, rdata_valid_o, pulses, p0 + 1);
    end
    @(negedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((!wbuf_empty_o || wq.size() != 0) && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    n_checks++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL drain: wbuf_empty_o=%b writes_outstanding=%0d required 1/0", wbuf_empty_o, wq.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if (bus_req !== 0 || rdata_valid_o !== 0 || rdata_o !== 32'h0 || wbuf_empty_o !== 1 || stall_o !== 0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b valid=%b rdata=%h empty=%b stall=%b required 0/0/0/1/0",
               bus_req, rdata_valid_o, rdata_o, wbuf_empty_o, stall_o);
    end
    rst = 0;
    cyc(1);
  endtask

  task automatic test_load_basic();
    int lat, p0;
    amem[32'h1FAF_F010] = 32'hDEAD_BEEF;
    bmem[32'h1FAF_F010] = 32'hDEAD_BEEF;
    addr_wait = 0; data_wait = 2;
    load(32'h1FAF_F010, lat);
    n_checks++;
    if (lat != 6) begin n_fail++; $display("FAIL load_latency_slow: got %0d required 6", lat); end
    p0 = pulses;
    cyc(3);
    n_checks++;
    if (pulses != p0) begin n_fail++; $display("FAIL load_single_pulse: extra pulses %0d required 0", pulses - p0); end
    data_wait = 0;
    load(32'h1FAF_F020, lat);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL load_latency_min: got %0d required 4", lat); end
  endtask

  task automatic test_wbuf_full();
    int st, st5;
    addr_en = 0; data_wait = 0;
    for (int i = 0; i < 4; i++) begin
      store(32'h1FAF_0000 + 32'(4 * i), 32'hA000_0000 | 32'(i), st);
      n_checks++;
      if (st != 0) begin n_fail++; $display("FAIL wbuf_fill_stall: store %0d stalled %0d required 0", i, st); end
    end
    fork
      store(32'h1FAF_0010, 32'hA000_0004, st5);
      begin
        cyc(4);
        n_checks++;
        if (stall_o !== 1'b1) begin n_fail++; $display("FAIL wbuf_full_stall: got %b required 1", stall_o); end
        addr_en = 1;
      end
    join
    n_checks++;
    if (st5 != 6) begin n_fail++; $display("FAIL wbuf_fifth_stall_cycles: got %0d required 6", st5); end
    wait_drain();
  endtask

  task automatic test_load_after_store();
    int st, lat, k;
    bit ld_done, acked, rd_seen, empty_checked;
    ld_done = 0; acked = 0; rd_seen = 0; empty_checked = 0;
    data_wait = 3;
    store(32'h1FAF_F000, 32'h1234_5678, st);
    fork
      begin
        load(32'h1FAF_F000, lat);
        ld_done = 1;
      end
      begin
        k = 0;
        while (!ld_done && k < 100) begin
          @(negedge clk); #2;
          k++;
          if (acked && !empty_checked) begin
            empty_checked = 1;
            n_checks++;
            if (wbuf_empty_o !== 1'b1) begin n_fail++; $display("FAIL wbuf_empty_after_pop: got %b required 1", wbuf_empty_o); end
          end
          if (bus_data_ok && pending && pend_wr) acked = 1;
          if (bus_req && !bus_wr && !rd_seen) begin
            rd_seen = 1;
            n_checks++;
            if (!acked || !wbuf_empty_o) begin
              n_fail++;
              $display("FAIL read_before_store_ack: store_acked=%b empty=%b required 1/1", acked, wbuf_empty_o);
            end
          end
        end
        n_checks++;
        if (!rd_seen || !empty_checked) begin n_fail++; $display("FAIL order_observed: rd=%b empty_chk=%b required 1/1", rd_seen, empty_checked); end
      end
    join
    data_wait = 0;
  endtask

  task automatic test_flush();
    int k, p0, lat;
    bit saw_req;
    data_wait = 3;
    p0 = pulses;
    req_valid = 1; req_uncached = 1; req_wr = 0; req_size = 2'd2; req_addr = 32'h1FAF_F030;
    k = 0;
    while (!(pending && !pend_wr) && k < 50) begin @(negedge clk); #1; k++; end
    flush = 1;
    cyc(1);
    flush = 0; req_valid = 0;
    cyc(6);
    n_checks++;
    if (pulses != p0 || pending || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_rdata: pulses=%0d pending=%b stall=%b required %0d/0/0", pulses, pending, stall_o, p0);
    end
    data_wait = 0;
    load(32'h1FAF_F010, lat);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL load_after_flush_latency: got %0d required 4", lat); end
    // A load flushed while still in IDLE must never reach the bus.
    req_valid = 1; req_uncached = 1; req_wr = 0; req_addr = 32'h1FAF_F050; flush = 1;
    cyc(1);
    req_valid = 0; flush = 0;
    saw_req = 0;
    for (int i = 0; i < 5; i++) begin cyc(1); if (bus_req) saw_req = 1; end
    n_checks++;
    if (saw_req) begin n_fail++; $display("FAIL flush_idle_issue: bus_req rose, required no request"); end
  endtask

  task automatic test_same_cycle();
    int st, k;
    addr_en = 0; data_wait = 0;
    for (int i = 0; i < 3; i++) store(32'h1FAF_1000 + 32'(4 * i), 32'hB000_0000 | 32'(i), st);
    data_en = 0; addr_en = 1;
    k = 0;
    while (!pending && k < 50) begin @(negedge clk); #1; k++; end
    data_en = 1;
    store(32'h1FAF_100C, 32'hB000_0003, st);
    n_checks++;
    if (st != 0) begin n_fail++; $display("FAIL push_pop_count3_stall: got %0d required 0", st); end
    data_en = 0;
    store(32'h1FAF_1010, 32'hB000_0004, st);
    n_checks++;
    if (st != 0) begin n_fail++; $display("FAIL count_after_push_pop: stall %0d required 0", st); end
    fork
      store(32'h1FAF_1014, 32'hB000_0005, st);
      begin
        cyc(2);
        n_checks++;
        if (stall_o !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b required 1", stall_o); end
        k = 0;
        while (!(pending && pend_wr) && k < 50) begin @(negedge clk); #1; k++; end
        data_en = 1;
        #1;
        n_checks++;
        if (stall_o !== 1'b1 || bus_data_ok !== 1'b1) begin
          n_fail++;
          $display("FAIL full_pushpop_reject: stall=%b data_ok=%b required 1/1", stall_o, bus_data_ok);
        end
      end
    join
    n_checks++;
    if (st != 3) begin n_fail++; $display("FAIL full_stall_cycles: got %0d required 3", st); end
    wait_drain();
  endtask

  task automatic test_reset_midread();
    int k, lat;
    data_wait = 0; data_en = 0;
    req_valid = 1; req_uncached = 1; req_wr = 0; req_size = 2'd2; req_addr = 32'h1FAF_F040;
    k = 0;
    while (!(pending && !pend_wr) && k < 50) begin @(negedge clk); #1; k++; end
    rst = 1;
    #1;
    n_checks++;
    if (bus_req !== 0 || wbuf_empty_o !== 1 || rdata_valid_o !== 0) begin
      n_fail++;
      $display("FAIL reset_midread: req=%b empty=%b valid=%b required 0/1/0", bus_req, wbuf_empty_o, rdata_valid_o);
    end
    req_valid = 0; data_en = 1;
    cyc(2);
    rst = 0;
    cyc(1);
    load(32'h1FAF_F010, lat);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL load_after_reset_latency: got %0d required 4", lat); end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_wbuf_full();
    test_load_after_store();
    test_flush();
    test_same_cycle();
    test_reset_midread();
    cyc(3);
    n_checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: loads=%0d writes=%0d required 0/0", rq.size(), wq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
